avg_tree_pipe: RTL

Streaming, pipelined averaging unit for the datapath library. Each accepted beat carries N = 2^LOG2_N unsigned words; a registered adder tree sums them and a final shift stage divides the sum. The divide is either the exact N-way average or a programmable right shift. The block generalises the fixed 8-input combinational averager to any power-of-two input count and width, and adds valid/ready flow control, pipelining and a per-beat shift mode.

---
 rtl/avg_tree_pipe.sv | 108 ++++++++++
 1 files changed

// File: rtl/avg_tree_pipe.sv
`timescale 1ns/1ps
// avg_tree_pipe: streaming averager for 2^LOG2_N words, built from a registered adder tree and a shift stage.
// Define AVG_SAT_EN to saturate out_data when the shifted sum overflows DATAWIDTH; otherwise it truncates.
module avg_tree_pipe #(
  parameter int DATAWIDTH = 16,
  parameter int LOG2_N    = 3,
  parameter int SAWIDTH   = 8
) (
  input  logic                             Clk,
  input  logic                             Rst,
  input  logic [(1<<LOG2_N)*DATAWIDTH-1:0] in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             mode,
  input  logic [SAWIDTH-1:0]               sa,
  output logic [DATAWIDTH+LOG2_N-1:0]      out_sum,
  output logic [DATAWIDTH-1:0]             out_data,
  output logic                             out_valid,
  input  logic                             out_ready
);
  localparam int N     = 1 << LOG2_N;
  localparam int SW    = DATAWIDTH + LOG2_N;
  localparam int NODES = 2 * N - 1;
  localparam int TOP   = NODES - 1;

  logic                         adv;
  logic                         accept;
  logic [SAWIDTH-1:0]           amtIn;
  logic [NODES*SW-1:0]          treeSum_q, treeSum_d;
  logic [LOG2_N:0]              valid_q, valid_d;
  logic [LOG2_N:0][SAWIDTH-1:0] shiftAmt_q, shiftAmt_d;
  logic [SW-1:0]                finalSum;
  logic [SW-1:0]                shiftedSum;
  logic [SAWIDTH-1:0]           finalAmt;
  logic [SW-1:0]                outSum_q;
  logic [DATAWIDTH-1:0]         outData_q, outData_d;
  logic                         outValid_q;

  // The whole pipeline advances together; the only combinational path is out_ready/out_valid -> in_ready.
  assign adv      = !outValid_q || out_ready;
  assign in_ready = adv && Rst;
  assign accept   = in_valid && in_ready;
  assign amtIn    = mode ? sa : SAWIDTH'(LOG2_N);

  // Tree level k occupies nodes starting at 2N - 2*(N>>k); level 0 holds the zero-extended input words.
  always_comb begin
    treeSum_d  = treeSum_q;
    valid_d    = valid_q;
    shiftAmt_d = shiftAmt_q;
    if (adv) begin
      for (int i = 0; i < N; i++) begin
        treeSum_d[i*SW +: SW] = SW'(in_data[i*DATAWIDTH +: DATAWIDTH]);
      end
      for (int k = 1; k <= LOG2_N; k++) begin
        for (int i = 0; i < N / 2; i++) begin
          if (i < (N >> k)) begin
            treeSum_d[(2*N - 2*(N >> k) + i)*SW +: SW] =
              treeSum_q[(2*N - 2*(N >> (k-1)) + 2*i)*SW +: SW] +
              treeSum_q[(2*N - 2*(N >> (k-1)) + 2*i + 1)*SW +: SW];
          end
        end
      end
      for (int k = LOG2_N; k > 0; k--) begin
        valid_d[k]    = valid_q[k-1];
        shiftAmt_d[k] = shiftAmt_q[k-1];
      end
      valid_d[0]    = accept;
      shiftAmt_d[0] = amtIn;
    end
  end

  assign finalSum = treeSum_q[TOP*SW +: SW];
  assign finalAmt = shiftAmt_q[LOG2_N];

  always_comb begin
    shiftedSum = (32'(finalAmt) >= 32'(SW)) ? '0 : (finalSum >> finalAmt);
`ifdef AVG_SAT_EN
    outData_d = ((shiftedSum >> DATAWIDTH) != '0) ? '1 : DATAWIDTH'(shiftedSum);
`else
    outData_d = DATAWIDTH'(shiftedSum);
`endif
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      treeSum_q  <= '0;
      valid_q    <= '0;
      shiftAmt_q <= '0;
      outSum_q   <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
    end else begin
      treeSum_q  <= treeSum_d;
      valid_q    <= valid_d;
      shiftAmt_q <= shiftAmt_d;
      if (adv) begin
        outValid_q <= valid_q[LOG2_N];
        outSum_q   <= finalSum;
        outData_q  <= outData_d;
      end
    end
  end

  assign out_sum   = outSum_q;
  assign out_data  = outData_q;
  assign out_valid = outValid_q;

endmodule
